// File: rtl/ibex_pkg.sv
// Shared operator and FSM types for the iterative multiplier/divider.
// Imported by the datapath, its interface bundle and the testbench.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_iter_fsm_e;

    function automatic logic md_is_div(md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Request/result bundle for ibex_multdiv_iter; the master issues operations,
// the slave is the multiplier/divider.
interface ibex_multdiv_iter_if
    import ibex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    // Handshake: a request transfers on a rising edge where in_valid & in_ready;
    // a result transfers on a rising edge where out_valid & out_ready, and
    // result stays stable while out_valid is high and out_ready is low.
    logic             in_valid;
    logic             in_ready;
    md_op_e           operator;
    logic [1:0]       signed_mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             data_ind_timing;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, operator, signed_mode, op_a, op_b, data_ind_timing,
               flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, operator, signed_mode, op_a, op_b, data_ind_timing,
               flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/ibex_multdiv_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for the final sign fix-up.
module ibex_multdiv_cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative radix-2 multiplier/divider (shift-add / restoring divide on magnitudes).
// Optional build macro IBEX_MULTDIV_ITER_DIT_EN enables the data_ind_timing_i input.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    md_iter_fsm_e     state_q, state_d;
    md_op_e           op_q, op_d;
    logic             res_neg_q, res_neg_d;
    logic             early_q, early_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic dit_in;
`ifdef IBEX_MULTDIV_ITER_DIT_EN
    assign dit_in = data_ind_timing_i;
`else
    logic unused_dit;
    assign unused_dit = data_ind_timing_i;
    assign dit_in     = 1'b0;
`endif

    logic             early_in;
    logic             sign_a, sign_b, b_zero, in_is_div;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign early_in  = EARLY_EXIT & ~dit_in;
    assign sign_a    = signed_mode_i[0] & op_a_i[WIDTH-1];
    assign sign_b    = signed_mode_i[1] & op_b_i[WIDTH-1];
    assign b_zero    = (op_b_i == '0);
    assign in_is_div = md_is_div(operator_i);

    ibex_multdiv_cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg_i (sign_a),
        .val_i (op_a_i),
        .val_o (abs_a)
    );

    ibex_multdiv_cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg_i (sign_b),
        .val_i (op_b_i),
        .val_o (abs_b)
    );

    // Multiply: acc += mcand when the multiplier LSB is set; mcand walks left.
    // Divide: acc[WIDTH-1:0] is the partial remainder, mplier shifts the
    // dividend out at the top and the quotient in at the bottom.
    logic [W2-1:0]    mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_borrow;
    logic [CNT_W-1:0] cnt_dec;
    logic [WIDTH-1:0] mplier_shr;
    logic             cur_is_div;

    assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign div_shift  = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, mcand_q[WIDTH-1:0]};
    assign div_borrow = div_diff[WIDTH+1];
    assign cnt_dec    = cnt_q - CNT_W'(1);
    assign mplier_shr = mplier_q >> 1;
    assign cur_is_div = md_is_div(op_q);

    // A zero-extended quotient/remainder negated at 2*WIDTH gives the same low
    // half as a WIDTH-bit negation, so one negator serves every operator.
    logic [W2-1:0]    fix_in, fix_out;
    logic [WIDTH-1:0] fix_res;

    always_comb begin
        fix_in = acc_q;
        if (op_q == MD_OP_REM) begin
            fix_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end else if (op_q == MD_OP_DIV) begin
            fix_in = {{WIDTH{1'b0}}, mplier_q};
        end
    end

    ibex_multdiv_cond_negate #(.WIDTH(W2)) u_fix (
        .neg_i (res_neg_q),
        .val_i (fix_in),
        .val_o (fix_out)
    );

    assign fix_res = (op_q == MD_OP_MULH) ? fix_out[W2-1:WIDTH] : fix_out[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_neg_d = res_neg_q;
        early_d   = early_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d    = operator_i;
                    early_d = early_in;
                    cnt_d   = CNT_W'(WIDTH);
                    acc_d   = '0;
                    if (in_is_div) begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_b};
                        mplier_d = abs_a;
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                    end
                    // A zero divisor yields an all-ones quotient that must not be negated.
                    case (operator_i)
                        MD_OP_REM: res_neg_d = sign_a;
                        MD_OP_DIV: res_neg_d = (sign_a ^ sign_b) & ~b_zero;
                        default:   res_neg_d = sign_a ^ sign_b;
                    endcase
                    if (in_is_div && b_zero && early_in) begin
                        result_d = (operator_i == MD_OP_DIV) ? '1 : op_a_i;
                        state_d  = DONE;
                    end else begin
                        state_d = COMP;
                    end
                end
            end
            COMP: begin
                cnt_d = cnt_dec;
                if (cur_is_div) begin
                    acc_d    = {{WIDTH{1'b0}},
                                div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]};
                    mplier_d = {mplier_q[WIDTH-2:0], ~div_borrow};
                end else begin
                    acc_d    = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shr;
                end
                if ((cnt_dec == '0) ||
                    (!cur_is_div && early_q && (mplier_shr == '0))) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= MD_OP_MULL;
            res_neg_q <= 1'b0;
            early_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            res_neg_q <= res_neg_d;
            early_q   <= early_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter at WIDTH=32 with EARLY_EXIT=1;
// directed corner cases, handshake/flush/reset scenarios and a random sweep.
module tb_ibex_multdiv_iter;
    import ibex_pkg::*;

    localparam int unsigned W = 32;
`ifdef IBEX_MULTDIV_ITER_DIT_EN
    localparam bit DIT_EN = 1'b1;
`else
    localparam bit DIT_EN = 1'b0;
`endif
    localparam int FULL_LAT = W + 2;
    localparam int MAX_WAIT = 200;

    logic clk;
    logic rst;

    ibex_multdiv_iter_if #(.WIDTH(W)) mdi ();

    ibex_multdiv_iter #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .in_valid_i        (mdi.in_valid),
        .in_ready_o        (mdi.in_ready),
        .operator_i        (mdi.operator),
        .signed_mode_i     (mdi.signed_mode),
        .op_a_i            (mdi.op_a),
        .op_b_i            (mdi.op_b),
        .data_ind_timing_i (mdi.data_ind_timing),
        .flush_i           (mdi.flush),
        .out_valid_o       (mdi.out_valid),
        .out_ready_i       (mdi.out_ready),
        .result_o          (mdi.result),
        .busy_o            (mdi.busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic logic [W-1:0] model(md_op_e op, logic [1:0] sm,
                                           logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb, r;
        sa = sm[0] ? {{32{a[W-1]}}, a} : {32'd0, a};
        sb = sm[1] ? {{32{b[W-1]}}, b} : {32'd0, b};
        case (op)
            MD_OP_MULL: begin r = sa * sb; return W'(r); end
            MD_OP_MULH: begin r = sa * sb; return W'(r >> W); end
            MD_OP_DIV: begin
                if (b == '0) return '1;
                r = sa / sb;
                return W'(r);
            end
            default: begin
                if (b == '0) return a;
                r = sa % sb;
                return W'(r);
            end
        endcase
    endfunction

    function automatic int exp_lat(md_op_e op, logic [1:0] sm, logic [W-1:0] b, logic dit);
        logic early;
        logic [W-1:0] mag;
        int n;
        early = !(DIT_EN && dit);
        if (op == MD_OP_DIV || op == MD_OP_REM) return (early && b == '0) ? 1 : FULL_LAT;
        if (!early) return FULL_LAT;
        mag = (sm[1] && b[W-1]) ? -b : b;
        n = 0;
        for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
        return 2 + ((n < 1) ? 1 : n);
    endfunction

    // driver: issue one op, measure latency, compare against the scoreboard
    task automatic do_op(input string tag, input md_op_e op, input logic [1:0] sm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic dit, input int hold);
        int lat;
        int el;
        logic [W-1:0] e;
        exp_q.push_back(model(op, sm, a, b));
        el = exp_lat(op, sm, b, dit);
        @(negedge clk);
        mdi.in_valid        = 1'b1;
        mdi.operator        = op;
        mdi.signed_mode     = sm;
        mdi.op_a            = a;
        mdi.op_b            = b;
        mdi.data_ind_timing = dit;
        mdi.out_ready       = (hold == 0);
        @(posedge clk);
        #1;
        mdi.in_valid        = 1'b0;
        mdi.data_ind_timing = ~dit;
        lat = 1;
        while (!mdi.out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(el));
        e = exp_q.pop_front();
        check({tag, "_res"}, 64'(mdi.result), 64'(e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(mdi.out_valid), 64'd1);
            check({tag, "_hold_res"}, 64'(mdi.result), 64'(e));
            check({tag, "_hold_inrdy"}, 64'(mdi.in_ready), 64'd0);
        end
        mdi.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 64'(mdi.busy), 64'd0);
    endtask

    initial begin
        int seen;
        logic [W-1:0] rb;
        md_op_e rop;

        rst                 = 1'b1;
        mdi.in_valid        = 1'b0;
        mdi.operator        = MD_OP_MULL;
        mdi.signed_mode     = 2'b00;
        mdi.op_a            = '0;
        mdi.op_b            = '0;
        mdi.data_ind_timing = 1'b0;
        mdi.flush           = 1'b0;
        mdi.out_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inrdy", 64'(mdi.in_ready), 64'd1);
        check("rst_outvld", 64'(mdi.out_valid), 64'd0);
        check("rst_busy", 64'(mdi.busy), 64'd0);
        check("rst_res", 64'(mdi.result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed corner cases
        do_op("mull_7x6", MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 0);
        do_op("mull_7x6_dit", MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b1, 0);
        do_op("mull_b0", MD_OP_MULL, 2'b00, 32'd9, 32'd0, 1'b0, 0);
        do_op("mulh_s_min", MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        do_op("mulh_u_max", MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op("mull_s_neg", MD_OP_MULL, 2'b11, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
        do_op("div_s_m7_2", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op("rem_s_m7_2", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op("div_min_m1", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op("rem_min_m1", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op("div_5_0", MD_OP_DIV, 2'b11, 32'd5, 32'd0, 1'b0, 0);
        do_op("rem_5_0", MD_OP_REM, 2'b11, 32'd5, 32'd0, 1'b0, 0);
        do_op("rem_m5_0", MD_OP_REM, 2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 0);
        do_op("div_5_0_dit", MD_OP_DIV, 2'b11, 32'd5, 32'd0, 1'b1, 0);
        do_op("rem_5_0_dit", MD_OP_REM, 2'b11, 32'd5, 32'd0, 1'b1, 0);
        do_op("divu_big", MD_OP_DIV, 2'b00, 32'hFFFF_FFF0, 32'd7, 1'b0, 0);

        // result held while the consumer stalls
        do_op("hold", MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 10);

        // flush during COMP cycle 5
        @(negedge clk);
        mdi.in_valid    = 1'b1;
        mdi.operator    = MD_OP_DIV;
        mdi.signed_mode = 2'b00;
        mdi.op_a        = 32'd100;
        mdi.op_b        = 32'd7;
        @(posedge clk);
        #1;
        mdi.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("flush_pre_busy", 64'(mdi.busy), 64'd1);
        @(negedge clk);
        mdi.flush = 1'b1;
        @(posedge clk);
        #1;
        mdi.flush = 1'b0;
        check("flush_busy", 64'(mdi.busy), 64'd0);
        check("flush_outvld", 64'(mdi.out_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mdi.out_valid) seen++;
        end
        check("flush_noval", 64'(seen), 64'd0);

        // flush outranks a simultaneous request
        @(negedge clk);
        mdi.in_valid = 1'b1;
        mdi.flush    = 1'b1;
        @(posedge clk);
        #1;
        mdi.in_valid = 1'b0;
        mdi.flush    = 1'b0;
        check("flush_vs_accept", 64'(mdi.busy), 64'd0);

        // random sweep
        for (int i = 0; i < 24; i++) begin
            rop = md_op_e'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = W'($urandom_range(0, 255));
                2:       rb = '0;
                default: rb = '1;
            endcase
            do_op($sformatf("rnd%0d", i), rop, 2'($urandom_range(0, 3)), $urandom, rb,
                  1'($urandom_range(0, 1)), 0);
        end

        // asynchronous reset in the middle of COMP
        @(negedge clk);
        mdi.in_valid    = 1'b1;
        mdi.operator    = MD_OP_MULL;
        mdi.signed_mode = 2'b00;
        mdi.op_a        = 32'd3;
        mdi.op_b        = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mdi.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("rstm_pre_busy", 64'(mdi.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rstm_inrdy", 64'(mdi.in_ready), 64'd1);
        check("rstm_outvld", 64'(mdi.out_valid), 64'd0);
        check("rstm_busy", 64'(mdi.busy), 64'd0);
        check("rstm_res", 64'(mdi.result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("div_3_1", MD_OP_DIV, 2'b00, 32'd3, 32'd1, 1'b0, 0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ibex_multdiv_iter.md
IBEX_MULTDIV_ITER -- requirements
Module: ibex_multdiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and 8..64.
REQ-002 SHALL have parameter EARLY_EXIT, default 1'b1; 1 allows multiply early termination and a divide-by-zero shortcut.
REQ-003 SHALL have port clk_i, input, 1, the only clock.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid_i, input, 1, request valid.
REQ-006 SHALL have port in_ready_o, output, 1, block can accept a request.
REQ-007 SHALL have port operator_i, input, ibex_pkg::md_op_e, operation: MD_OP_MULL, MD_OP_MULH, MD_OP_DIV or MD_OP_REM.
REQ-008 SHALL have port signed_mode_i, input, 2, bit0 = op_a signed, bit1 = op_b signed.
REQ-009 SHALL have port op_a_i, input, WIDTH, multiplicand or dividend.
REQ-010 SHALL have port op_b_i, input, WIDTH, multiplier or divisor.
REQ-011 SHALL have port data_ind_timing_i, input, 1, force full-length iteration.
REQ-012 SHALL have port flush_i, input, 1, abort the operation in flight.
REQ-013 SHALL have port out_valid_o, output, 1, result valid.
REQ-014 SHALL have port out_ready_i, input, 1, consumer accepts the result.
REQ-015 SHALL have port result_o, output, WIDTH, the result.
REQ-016 SHALL have port busy_o, output, 1, state is not IDLE.

Function
REQ-017 SHALL contain its own adder and negators; no ALU sharing and no external intermediate registers.
REQ-018 SHALL use FSM states IDLE, COMP, FIX and DONE.
REQ-019 SHALL drive in_ready_o=1 only in IDLE; an accept is in_valid_i & in_ready_o.
REQ-020 SHALL latch the operator, the result sign and |op_a|,|op_b| (per signed_mode_i) on accept, load the counter with WIDTH and go to COMP.
REQ-021 SHALL, in COMP, do one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) on magnitudes and decrement the counter.
REQ-022 SHALL leave COMP for FIX when the counter reaches 0, or, for multiply, when the remaining multiplier bits are 0 and early exit is active.
REQ-023 SHALL, in FIX, conditionally two's-complement negate the product, quotient or remainder in one cycle, then go to DONE.
REQ-024 SHALL sign the product/quotient as sign_a^sign_b and the remainder as sign_a.
REQ-025 SHALL compute a 2*WIDTH product; MULL returns the low half and MULH the high half.
REQ-026 SHALL assert out_valid_o only in DONE and hold result_o stable until out_ready_i; DONE exits to IDLE on out_valid_o & out_ready_i.
REQ-027 SHALL take WIDTH+2 cycles from accept edge to out_valid_o for divide and for data-independent-timing (DIT) multiply; early-exit multiply takes 3 cycles minimum.
REQ-028 SHALL, on divide by zero with early exit active, go IDLE->DONE with DIV = all-ones and REM = op_a (latency 1).
REQ-029 SHALL, on divide by zero with DIT, iterate fully and naturally yield the same values, with the FIX sign change suppressed.
REQ-030 SHALL give DIV(MIN,-1)=MIN and REM(MIN,-1)=0.
REQ-031 SHALL, on flush_i in any state, go to IDLE on the next edge with out_valid_o=0; flush_i outranks a simultaneous accept.
REQ-032 SHALL sample data_ind_timing_i only at accept.

Reset
REQ-033 SHALL, on rst_i, go immediately to IDLE with out_valid_o=0, in_ready_o=1, busy_o=0, result_o=0 and all datapath registers at 0; this includes reset mid-operation.

Configuration
REQ-034 SHALL, with IBEX_MULTDIV_ITER_DIT_EN defined, honour data_ind_timing_i: when 1, early exit and the divide-by-zero shortcut are disabled.
REQ-035 SHALL, without IBEX_MULTDIV_ITER_DIT_EN, ignore data_ind_timing_i (treated as 0) and apply only EARLY_EXIT.

Structure
REQ-036 SHALL keep md_op_e and the new md_iter_fsm_e state enum in ibex_pkg.
REQ-037 SHALL use one sub-module, ibex_multdiv_cond_negate (WIDTH-parameterised conditional two's-complement), instanced for operand abs and for result FIX.
REQ-038 SHALL size the counter at $clog2(WIDTH)+1 bits.

Verification
REQ-039 SHALL cover, at WIDTH=32: MULL 7*6 with early exit -> 42, latency at most 5 cycles; with DIT -> 42 at latency 34.
REQ-040 SHALL cover: MULH signed 0x80000000*0x80000000 -> 0x40000000; MULH unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-041 SHALL cover: DIV signed -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
REQ-042 SHALL cover: DIV 5/0 -> 0xFFFFFFFF at latency 1; REM 5/0 -> 5; with DIT both at latency 34.
REQ-043 SHALL cover: out_ready_i held low 10 cycles in DONE -> result stable, in_ready_o=0; flush_i at COMP cycle 5 -> IDLE next cycle, no out_valid_o.
REQ-044 SHALL cover: rst_i pulsed mid-COMP -> outputs at reset values immediately; next op 3/1 DIV -> 3.
